// File: rtl/shader_scatterm_pkg.sv
// rtl/shader_scatterm_pkg.sv - shared types for the fragment channel scatter unit
package shader_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] channel_t;
  typedef nibble_t [3:0] frag_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } scatter_state_e;

endpackage

// File: rtl/shader_scatterm_if.sv
// rtl/shader_scatterm_if.sv - channel write input stream and assembled fragment output
interface shader_scatterm_if;
  import shader_pkg::*;

  logic     s_valid;
  logic     s_ready;
  channel_t s_map_to;
  nibble_t  s_wdata;
  logic     s_last;
  logic     m_valid;
  logic     m_ready;
  frag_t    m_frag;
  logic [3:0] m_mask;

  modport slave (
    input  s_valid, s_map_to, s_wdata, s_last, m_ready,
    output s_ready, m_valid, m_frag, m_mask
  );

  modport master (
    output s_valid, s_map_to, s_wdata, s_last, m_ready,
    input  s_ready, m_valid, m_frag, m_mask
  );
endinterface

// File: rtl/shader_scatterm_lane.sv
// rtl/shader_scatterm_lane.sv - one assembly channel: nibble, written flag, collision hit
// Collision hit is only generated when SHADER_SCATTER_COLLIDE_EN is defined.
module shader_scatter_lane
  import shader_pkg::*;
#(
  parameter logic [3:0] FILL = 4'h0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    wr_en_i,
  input  logic    clr_i,
  input  nibble_t wdata_i,
  output nibble_t merged_o,
  output logic    merged_wr_o,
  output logic    hit_o
);

  nibble_t nib_q, nib_d;
  logic    written_q, written_d;

  // merged view includes this cycle's write so a last write can bypass the register
  assign merged_o    = wr_en_i ? wdata_i : nib_q;
  assign merged_wr_o = written_q | wr_en_i;

  always_comb begin
    nib_d     = merged_o;
    written_d = merged_wr_o;
    if (clr_i) begin
      nib_d     = FILL;
      written_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nib_q     <= FILL;
      written_q <= 1'b0;
    end else begin
      nib_q     <= nib_d;
      written_q <= written_d;
    end
  end

`ifdef SHADER_SCATTER_COLLIDE_EN
  assign hit_o = wr_en_i & written_q;
`else
  assign hit_o = 1'b0;
`endif

endmodule

// File: rtl/shader_scatterm.sv
// rtl/shader_scatterm.sv - scatters nibble channel writes into a 4-channel fragment
// Optional collision flag built only when SHADER_SCATTER_COLLIDE_EN is defined.
module shader_scatterm
  import shader_pkg::*;
#(
  parameter logic [3:0] FILL = 4'h0
) (
  input  logic aclk,
  input  logic aresetn,
  shader_scatterm_if.slave bus,
  output logic collide,
  input  logic collide_clr
);

  scatter_state_e state_q, state_d;
  logic       accept, out_free, load, clr;
  frag_t      merged_frag;
  logic [3:0] merged_mask, hit;
  frag_t      m_frag_q, m_frag_d;
  logic [3:0] m_mask_q, m_mask_d;
  logic       m_valid_q, m_valid_d;

  assign bus.s_ready = (state_q != HOLD);
  assign accept      = bus.s_valid & bus.s_ready;
  assign out_free    = ~m_valid_q | bus.m_ready;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    shader_scatter_lane #(.FILL(FILL)) u_lane (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .wr_en_i    (accept && (bus.s_map_to == channel_t'(i))),
      .clr_i      (clr),
      .wdata_i    (bus.s_wdata),
      .merged_o   (merged_frag[i]),
      .merged_wr_o(merged_mask[i]),
      .hit_o      (hit[i])
    );
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!bus.s_last) begin
            state_d = ACCUM;
          end else if (out_free) begin
            load    = 1'b1;
            clr     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      // no writes are accepted here, so the merged view equals the held assembly
      HOLD: begin
        if (m_valid_q && bus.m_ready) begin
          load    = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_frag_d  = m_frag_q;
    m_mask_d  = m_mask_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_frag_d  = merged_frag;
      m_mask_d  = merged_mask;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_frag_q  <= {4{FILL}};
      m_mask_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_frag_q  <= m_frag_d;
      m_mask_q  <= m_mask_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_frag  = m_frag_q;
  assign bus.m_mask  = m_mask_q;

`ifdef SHADER_SCATTER_COLLIDE_EN
  logic collide_q, collide_d;

  always_comb begin
    collide_d = collide_q;
    if (|hit)            collide_d = 1'b1;
    else if (collide_clr) collide_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) collide_q <= 1'b0;
    else          collide_q <= collide_d;
  end

  assign collide = collide_q;
`else
  logic unused_collide;
  assign unused_collide = collide_clr ^ (|hit);
  assign collide        = 1'b0;
`endif

endmodule

// File: tb/tb_shader_scatterm.sv
// tb/tb_shader_scatterm.sv - scoreboard bench for shader_scatterm (two FILL values)
module tb_shader_scatterm;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic collide, collide_clr;
  logic collide2, collide_clr2;
  always #5 clk = ~clk;

  shader_scatterm_if bus ();
  shader_scatterm_if bus2 ();

  shader_scatterm #(.FILL(4'h0)) dut (
    .aclk(clk), .aresetn(aresetn), .bus(bus.slave),
    .collide(collide), .collide_clr(collide_clr)
  );

  shader_scatterm #(.FILL(4'hF)) dut2 (
    .aclk(clk), .aresetn(aresetn), .bus(bus2.slave),
    .collide(collide2), .collide_clr(collide_clr2)
  );

  typedef struct packed {
    logic [15:0] frag;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_q2[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int mv_run = 0;
  int wr_waits = 0;

`ifdef SHADER_SCATTER_COLLIDE_EN
  localparam logic COLL_EXP = 1'b1;
`else
  localparam logic COLL_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [3:0] d, input logic last);
    int n;
    bus.s_valid  = 1'b1;
    bus.s_map_to = ch;
    bus.s_wdata  = d;
    bus.s_last   = last;
    n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    wr_waits += n;
    if (n >= 20) chk("wr_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.m_valid) mv_run++;
    else             mv_run = 0;
    if (aresetn && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected", {16'h0, bus.m_frag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_frag", 32'(bus.m_frag), 32'(e.frag));
        chk("mon_mask", 32'(bus.m_mask), 32'(e.mask));
      end
    end
  end

  always @(negedge clk) begin
    if (aresetn && bus2.m_valid && bus2.m_ready) begin
      if (exp_q2.size() == 0) begin
        chk("mon2_unexpected", {16'h0, bus2.m_frag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q2.pop_front();
        chk("mon2_frag", 32'(bus2.m_frag), 32'(e.frag));
        chk("mon2_mask", 32'(bus2.m_mask), 32'(e.mask));
      end
    end
  end

  initial begin
    int n;
    bus.s_valid = 0; bus.s_map_to = 0; bus.s_wdata = 0; bus.s_last = 0; bus.m_ready = 1;
    bus2.s_valid = 0; bus2.s_map_to = 0; bus2.s_wdata = 0; bus2.s_last = 0; bus2.m_ready = 1;
    collide_clr = 0;
    collide_clr2 = 0;
    #12;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_frag", 32'(bus.m_frag), 32'h0000);
    chk("rst_m_mask", 32'(bus.m_mask), 32'd0);
    chk("rst_collide", 32'(collide), 32'd0);
    chk("rst2_m_frag", 32'(bus2.m_frag), 32'hFFFF);
    @(negedge clk);
    aresetn = 1'b1;
    idle(2);

    // two channels, last on c2
    wr(2'd0, 4'hA, 1'b0);
    exp_q.push_back('{frag: 16'h050A, mask: 4'b0101});
    wr(2'd2, 4'h5, 1'b1);
    chk("lat_m_valid", 32'(bus.m_valid), 32'd1);
    chk("lat_m_frag", 32'(bus.m_frag), 32'h050A);
    idle(3);

    // stall: second fragment waits in HOLD
    bus.m_ready = 1'b0;
    exp_q.push_back('{frag: 16'h0030, mask: 4'b0010});
    wr(2'd1, 4'h3, 1'b1);
    exp_q.push_back('{frag: 16'h0001, mask: 4'b0001});
    wr(2'd0, 4'h1, 1'b1);
    chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
    idle(2);
    chk("hold_s_ready2", 32'(bus.s_ready), 32'd0);
    chk("hold_m_frag", 32'(bus.m_frag), 32'h0030);
    bus.m_ready = 1'b1;
    idle(1);
    chk("drain_m_frag", 32'(bus.m_frag), 32'h0001);
    chk("drain_s_ready", 32'(bus.s_ready), 32'd1);
    idle(3);

    // same channel twice: last write wins, collide flag
    wr(2'd1, 4'h3, 1'b0);
    exp_q.push_back('{frag: 16'h0070, mask: 4'b0010});
    wr(2'd1, 4'h7, 1'b1);
    chk("coll_set", 32'(collide), 32'(COLL_EXP));
    idle(2);
    chk("coll_sticky", 32'(collide), 32'(COLL_EXP));
    collide_clr = 1'b1;
    idle(1);
    collide_clr = 1'b0;
    chk("coll_clr", 32'(collide), 32'd0);
    idle(2);

    // reset mid-fragment with a fragment sitting in the output register
    bus.m_ready = 1'b0;
    wr(2'd2, 4'h9, 1'b1);
    wr(2'd3, 4'hC, 1'b0);
    chk("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("mid_rst_m_frag", 32'(bus.m_frag), 32'h0000);
    @(negedge clk);
    aresetn = 1'b1;
    bus.m_ready = 1'b1;
    idle(1);
    exp_q.push_back('{frag: 16'h0002, mask: 4'b0001});
    wr(2'd0, 4'h2, 1'b1);
    chk("post_rst_m_frag", 32'(bus.m_frag), 32'h0002);
    idle(3);

    // back-to-back single-write fragments on c0..c3
    wr_waits = 0;
    exp_q.push_back('{frag: 16'h0001, mask: 4'b0001});
    exp_q.push_back('{frag: 16'h0020, mask: 4'b0010});
    exp_q.push_back('{frag: 16'h0300, mask: 4'b0100});
    exp_q.push_back('{frag: 16'h4000, mask: 4'b1000});
    for (int i = 0; i < 4; i++) wr(2'(i), 4'(i + 1), 1'b1);
    @(negedge clk);
    #1;
    chk("burst_mv_run", 32'(mv_run), 32'd4);
    chk("burst_waits", 32'(wr_waits), 32'd0);
    idle(3);

    // FILL = 4'hF instance
    @(posedge clk);
    #1;
    bus2.s_valid = 1'b1; bus2.s_map_to = 2'd0; bus2.s_wdata = 4'h1; bus2.s_last = 1'b1;
    exp_q2.push_back('{frag: 16'hFFF1, mask: 4'b0001});
    @(posedge clk);
    #1;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0;
    chk("fillf_m_frag", 32'(bus2.m_frag), 32'hFFF1);

    n = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 50) begin
      n++;
      @(posedge clk);
    end
    idle(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    chk("sb2_drain", 32'(exp_q2.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shader_scatterm.md
# shader_scatterM

Fragment de-swizzle / channel scatter unit: the write-back counterpart of the fragment swizzle mux. It accepts a stream of single-nibble channel writes, each tagged with a 2-bit destination channel, and assembles them into a 4-channel, 16-bit fragment. On the write marked last, it hands the fragment downstream through a registered valid/ready output. It sits between the shader ALU result path and the fragment write port, and double-buffers so one write per cycle is sustained.

## Interface
- FILL, 4'h0, value placed in every channel not written within a fragment.
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  channel write valid.
- s_ready  out  1  channel write accepted when s_valid & s_ready.
- s_map_to  in  2  destination channel (0..3).
- s_wdata  in  4  nibble to write.
- s_last  in  1  final write of the current fragment.
- m_valid  out  1  assembled fragment valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.
- m_frag  out  16  {c3,c2,c1,c0}; c0 = bits [3:0].
- m_mask  out  4  bit n set when channel n was written in this fragment.
- collide  out  1  sticky flag: a channel was written twice within one fragment.
- collide_clr  in  1  clears collide.

## Operation
- The assembly register holds 4 nibbles (reset/initial value FILL) plus a 4-bit written mask. The output register holds m_frag, m_mask and m_valid.
- Each accepted write stores s_wdata into channel s_map_to and sets that channel's mask bit. If the mask bit is already set, the new write wins.
- The merged fragment is the assembly contents with the current write applied.
- "Output free" means m_valid=0, or m_valid & m_ready in the same cycle.
- FSM states:
  - IDLE: assembly empty, mask 0.
  - ACCUM: at least one channel written.
  - HOLD: fragment complete, output register occupied.
- IDLE/ACCUM, accepted write with s_last=0: goes to ACCUM.
- IDLE/ACCUM, accepted write with s_last=1:
  - Output free: the merged fragment loads into the output register. The assembly resets to FILL and mask 0. State goes to IDLE.
  - Output not free: the merged fragment stays in the assembly register. State goes to HOLD.
- HOLD: s_ready=0. When m_valid & m_ready, the assembly loads into the output register in that same cycle, the assembly clears, and state goes to IDLE.
- s_ready = (state != HOLD).
- m_valid clears on m_valid & m_ready unless a new fragment loads in the same cycle.
- Reset (asynchronous, at any time including mid-fragment) forces:
  - state IDLE, assembly all FILL, mask 0;
  - m_valid 0, m_frag {4{FILL}}, m_mask 0;
  - collide 0.
- Reset output values: s_ready=1 (combinational from IDLE), m_valid=0, m_frag={4{FILL}}, m_mask=0, collide=0.

## Timing
- Latency: a fragment whose s_last write is accepted in cycle N presents m_valid=1 in cycle N+1 when the output is free in cycle N.
- Throughput: one write per cycle; one-write fragments sustain one fragment per cycle while m_ready=1.
- Outputs m_valid, m_frag, m_mask and collide are registered. s_ready is combinational from state only, with no path from m_ready.
- Under a stall, at most one complete fragment waits (HOLD) behind the output register.
- collide sets in cycle N+1 after a colliding write is accepted in cycle N. If set and collide_clr coincide, set wins.

## Configuration
- SHADER_SCATTER_COLLIDE_EN defined: collision detection and collide/collide_clr behaviour as above.
- Not defined: collide is tied to 0, collide_clr is ignored, and no detection logic is built. Last-write-wins data behaviour is unchanged.

## Structure
- shader_pkg holds:
  - nibble_t (logic [3:0]);
  - channel_t (logic [1:0]);
  - frag_t (packed array [3:0] of nibble_t);
  - the FSM state enum scatter_state_e {IDLE, ACCUM, HOLD}.
- Sub-module shader_scatter_lane, instantiated four times. Each lane holds one nibble plus its written flag and implements write, clear-to-FILL, and collision detect.

## Test plan
- FILL=0; write c0=4'hA, then c2=4'h5 with last; m_ready=1 → next cycle m_valid=1, m_frag=16'h050A, m_mask=4'b0101.
- m_ready=0; fragment A (c1=4'h3, last), then fragment B (c0=4'h1, last) → B enters HOLD and s_ready=0. Raise m_ready → A drains; next cycle m_frag=16'h0001, s_ready=1.
- Write c1=4'h3, then c1=4'h7 with last → m_frag=16'h0070, m_mask=4'b0010. With the macro, collide=1 until collide_clr; without it, collide stays 0.
- Write c3=4'hC (no last), then assert aresetn=0 mid-fragment → m_valid=0 and s_ready=1. After release, write c0=4'h2 with last → m_frag=16'h0002, m_mask=4'b0001.
- Single-write last fragments on c0..c3 on consecutive cycles with m_ready=1 → four consecutive m_valid cycles and s_ready never drops.
- FILL=4'hF; write c0=4'h1 with last → m_frag=16'hFFF1, m_mask=4'b0001.
